// File: rtl/vga_console_writer.sv
// vga_console_writer: turns an ASCII byte stream into single-cycle tile writes
// on the VGA text controller's write port, tracking an 80x30 cursor and
// running row/screen clears in hardware.
module vga_console_writer #(
  parameter int unsigned                 C_AXI_ADDR_WIDTH = 15,
  parameter int unsigned                 C_AXI_DATA_WIDTH = 32,
  parameter int unsigned                 COLS             = 80,
  parameter int unsigned                 ROWS             = 30,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] BUF_BASE         = 15'h4000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            char_valid_i,
  input  logic [7:0]                      char_data_i,
  output logic                            char_ready_o,
  input  logic                            clear_i,
  output logic                            busy_o,
  output logic [6:0]                      cursor_col_o,
  output logic [4:0]                      cursor_row_o,
  output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
  output logic                            axil_wready_o
);

  localparam int unsigned IDX_W  = 12;
  localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;

  localparam logic [IDX_W-1:0] ROW_TILES    = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] SCREEN_TILES = IDX_W'(COLS * ROWS);
  localparam logic [6:0]       COL_LAST     = 7'(COLS - 1);
  localparam logic [4:0]       ROW_LAST     = 5'(ROWS - 1);
  localparam logic [7:0]       SPACE        = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [6:0]                  col_q, col_d;
  logic [4:0]                  row_q, row_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        wr_q, wr_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                  byte_q, byte_d;

  logic             char_ready_c;
  logic             accept_c;
  logic             inc_row_c;
  logic             lf_c;
  logic [IDX_W-1:0] row_base_c;
  logic [IDX_W-1:0] tile_idx_c;

  // Tile index of the cursor; row*80 as a shift-add
  generate
    if (COLS == 80) begin : g_row80
      assign row_base_c = (IDX_W'(row_q) << 6) + (IDX_W'(row_q) << 4);
    end else begin : g_rowgen
      assign row_base_c = IDX_W'(32'(row_q) * COLS);
    end
  endgenerate
  assign tile_idx_c = row_base_c + IDX_W'(col_q);

  assign char_ready_c = (state_q == IDLE) & ~clear_i & ~rst_i;
  assign accept_c     = char_valid_i & char_ready_c;

  // Next-state, cursor update and write-strobe generation
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    idx_d     = idx_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    byte_d    = byte_q;
    inc_row_c = 1'b0;
    lf_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clear_i || (accept_c && char_data_i == 8'h0C)) begin
          // First screen-clear strobe leaves on the entry edge
          state_d = CLR_ALL;
          wr_d    = 1'b1;
          addr_d  = BUF_BASE;
          byte_d  = SPACE;
          idx_d   = IDX_W'(1);
        end else if (accept_c) begin
          if (char_data_i >= 8'h20 && char_data_i <= 8'h7E) begin
            wr_d   = 1'b1;
            addr_d = BUF_BASE + C_AXI_ADDR_WIDTH'(tile_idx_c);
            byte_d = char_data_i;
            if (col_q == COL_LAST) begin
              col_d     = '0;
              inc_row_c = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (char_data_i == 8'h0D) begin
            col_d = '0;
          end else if (char_data_i == 8'h0A) begin
            col_d     = '0;
            inc_row_c = 1'b1;
            lf_c      = 1'b1;
          end else if (char_data_i == 8'h08) begin
            if (col_q != 7'd0) col_d = col_q - 7'd1;
          end

          if (inc_row_c) begin
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = CLR_ROW;
              if (lf_c) begin
                // No byte strobe in flight, so the row clear starts now
                wr_d   = 1'b1;
                addr_d = BUF_BASE;
                byte_d = SPACE;
                idx_d  = IDX_W'(1);
              end else begin
                idx_d = '0;
              end
            end else begin
              row_d = row_q + 5'd1;
            end
          end
        end
      end

      CLR_ROW: begin
        if (idx_q == ROW_TILES) begin
          state_d = IDLE;
        end else begin
          wr_d   = 1'b1;
          addr_d = BUF_BASE + C_AXI_ADDR_WIDTH'(idx_q);
          byte_d = SPACE;
          idx_d  = idx_q + IDX_W'(1);
        end
      end

      CLR_ALL: begin
        if (idx_q == SCREEN_TILES) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          wr_d   = 1'b1;
          addr_d = BUF_BASE + C_AXI_ADDR_WIDTH'(idx_q);
          byte_d = SPACE;
          idx_d  = idx_q + IDX_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, cursor and write-port registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
    end
  end

  assign char_ready_o  = char_ready_c;
  assign busy_o        = (state_q != IDLE);
  assign cursor_col_o  = col_q;
  assign cursor_row_o  = row_q;
  assign axil_wready_o = wr_q;
  assign axil_waddr_o  = addr_q;
  assign axil_wdata_o  = C_AXI_DATA_WIDTH'(byte_q);
  assign axil_wstrb_o  = wr_q ? STRB_W'(1) : '0;

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer: strobes are captured into queues on
// the falling edge and compared against hand-computed addresses and data.
module tb_vga_console_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        char_valid_i;
  logic [7:0]  char_data_i;
  logic        char_ready_o;
  logic        clear_i;
  logic        busy_o;
  logic [6:0]  cursor_col_o;
  logic [4:0]  cursor_row_o;
  logic [31:0] axil_wdata_o;
  logic [3:0]  axil_wstrb_o;
  logic [14:0] axil_waddr_o;
  logic        axil_wready_o;

  vga_console_writer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .char_valid_i  (char_valid_i),
    .char_data_i   (char_data_i),
    .char_ready_o  (char_ready_o),
    .clear_i       (clear_i),
    .busy_o        (busy_o),
    .cursor_col_o  (cursor_col_o),
    .cursor_row_o  (cursor_row_o),
    .axil_wdata_o  (axil_wdata_o),
    .axil_wstrb_o  (axil_wstrb_o),
    .axil_waddr_o  (axil_waddr_o),
    .axil_wready_o (axil_wready_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [14:0] s_addr[$];
  logic [31:0] s_data[$];
  logic [3:0]  s_strb[$];
  logic        s_busy[$];
  logic        s_rdy[$];
  int          s_cyc[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Capture every write strobe mid-cycle
  always @(negedge clk_i) begin
    if (axil_wready_o === 1'b1) begin
      s_addr.push_back(axil_waddr_o);
      s_data.push_back(axil_wdata_o);
      s_strb.push_back(axil_wstrb_o);
      s_busy.push_back(busy_o);
      s_rdy.push_back(char_ready_o);
      s_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_q();
    s_addr.delete(); s_data.delete(); s_strb.delete();
    s_busy.delete(); s_rdy.delete(); s_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Offer one byte and hold it until accepted
  task automatic send(input logic [7:0] b);
    int n = 0;
    char_valid_i = 1'b1;
    char_data_i  = b;
    #1;
    while (char_ready_o !== 1'b1 && n < 4000) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 4000) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk_i); #1;
    char_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o !== 1'b0 && n < 3000) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int bad;
    int n0;
    int n;

    rst_i = 1'b1; char_valid_i = 1'b0; char_data_i = '0; clear_i = 1'b0;
    tick(3);

    // Reset state
    chk("rst_ready", 32'(char_ready_o), 32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_wr",    32'(axil_wready_o), 32'd0);
    chk("rst_addr",  32'(axil_waddr_o), 32'd0);
    chk("rst_data",  axil_wdata_o,      32'd0);
    chk("rst_strb",  32'(axil_wstrb_o), 32'd0);
    chk("rst_cur",   {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
    rst_i = 1'b0;
    tick(1);
    clr_q();

    // 1: single printable byte
    send(8'h41);
    chk("t1_col", 32'(cursor_col_o), 32'd1);
    chk("t1_row", 32'(cursor_row_o), 32'd0);
    tick(2);
    chk("t1_nstb", 32'(s_addr.size()), 32'd1);
    if (s_addr.size() >= 1) begin
      chk("t1_addr", 32'(s_addr[0]), 32'h4000);
      chk("t1_data", s_data[0],      32'h41);
      chk("t1_strb", 32'(s_strb[0]), 32'h1);
    end

    // 2: LF then 'C', then CR
    clr_q();
    send(8'h0A);
    send(8'h43);
    send(8'h0D);
    tick(2);
    chk("t2_nstb", 32'(s_addr.size()), 32'd1);
    if (s_addr.size() >= 1) begin
      chk("t2_addr", 32'(s_addr[0]), 32'h4050);
      chk("t2_data", s_data[0],      32'h43);
    end
    chk("t2_cur", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd1, 7'd0});

    // 3: move to (79,29) and wrap
    for (int i = 0; i < 28; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h20);
    chk("t3_pre_cur", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd29, 7'd79});
    tick(2);
    clr_q();
    send(8'h43);
    wait_idle();
    tick(1);
    chk("t3_nstb", 32'(s_addr.size()), 32'd81);
    if (s_addr.size() == 81) begin
      chk("t3_addr0", 32'(s_addr[0]), 32'h495F);
      chk("t3_data0", s_data[0],      32'h43);
      bad = 0;
      for (int i = 1; i <= 80; i++)
        if (32'(s_addr[i]) != 32'h4000 + 32'(i - 1) || s_data[i] !== 32'h20 ||
            s_strb[i] !== 4'b0001 || s_busy[i] !== 1'b1 || s_rdy[i] !== 1'b0) bad++;
      chk("t3_clr_bad", 32'(bad), 32'd0);
      chk("t3_gap0", 32'(s_cyc[1] - s_cyc[0]), 32'd1);
      chk("t3_span", 32'(s_cyc[80] - s_cyc[1]), 32'd79);
    end
    chk("t3_cur",   {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
    chk("t3_ready", 32'(char_ready_o), 32'd1);

    // 4: clear_i beats a simultaneous byte
    send(8'h78);
    send(8'h79);
    tick(2);
    clr_q();
    clear_i = 1'b1; char_valid_i = 1'b1; char_data_i = 8'h5A;
    #1;
    chk("t4_ready_clr", 32'(char_ready_o), 32'd0);
    @(posedge clk_i); #1;
    clear_i = 1'b0; char_valid_i = 1'b0;
    chk("t4_busy", 32'(busy_o), 32'd1);
    chk("t4_hold_col", 32'(cursor_col_o), 32'd2);
    wait_idle();
    tick(1);
    chk("t4_nstb", 32'(s_addr.size()), 32'd2400);
    if (s_addr.size() == 2400) begin
      bad = 0;
      for (int i = 0; i < 2400; i++)
        if (32'(s_addr[i]) != 32'h4000 + 32'(i) || s_data[i] !== 32'h20) bad++;
      chk("t4_clr_bad", 32'(bad), 32'd0);
      chk("t4_last", 32'(s_addr[2399]), 32'h495F);
      chk("t4_span", 32'(s_cyc[2399] - s_cyc[0]), 32'd2399);
    end
    chk("t4_cur",   {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
    chk("t4_ready", 32'(char_ready_o), 32'd1);

    // 5: ten bytes streamed with valid held high
    clr_q();
    char_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      char_data_i = 8'h30 + 8'(i);
      @(posedge clk_i); #1;
    end
    char_valid_i = 1'b0;
    tick(2);
    chk("t5_nstb", 32'(s_addr.size()), 32'd10);
    if (s_addr.size() == 10) begin
      bad = 0;
      for (int i = 0; i < 10; i++)
        if (32'(s_addr[i]) != 32'h4000 + 32'(i) || s_data[i] != 32'h30 + 32'(i)) bad++;
      chk("t5_bad",  32'(bad), 32'd0);
      chk("t5_span", 32'(s_cyc[9] - s_cyc[0]), 32'd9);
    end
    chk("t5_cur", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd0, 7'd10});

    // 6: reset in the middle of a form-feed screen clear
    clr_q();
    send(8'h0C);
    n = 0;
    while (s_addr.size() < 100 && n < 500) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 500) chk("t6_timeout", 32'(n), 32'd0);
    chk("t6_hold_col", 32'(cursor_col_o), 32'd10);
    rst_i = 1'b1;
    n0 = s_addr.size();
    @(posedge clk_i); #1;
    chk("t6_busy",  32'(busy_o),        32'd0);
    chk("t6_wr",    32'(axil_wready_o), 32'd0);
    chk("t6_addr",  32'(axil_waddr_o),  32'd0);
    chk("t6_cur",   {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
    chk("t6_rdy_in_rst", 32'(char_ready_o), 32'd0);
    rst_i = 1'b0;
    tick(1);
    chk("t6_ready", 32'(char_ready_o), 32'd1);
    tick(5);
    chk("t6_nstb", 32'(s_addr.size()), 32'(n0 + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
